// File: rtl/lc3b_types.sv
// Shared types for the victim cache: FSM state encoding.
package lc3b_types;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WB,
    ST_RESP,
    ST_FLUSH,
    ST_FLUSH_WB,
    ST_FLUSH_DONE
  } vc_state_t;

endpackage

// File: rtl/vc_lru_ages.sv
// Per-entry LRU ages; ages always form a permutation of 0..ENTRIES-1.
module vc_lru_ages #(
  parameter  int ENTRIES = 8,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          touch_en,
  input  logic [IW-1:0] touch_idx,
  output logic [IW-1:0] lru_idx
);

  logic [IW-1:0] age [ENTRIES];
  logic [IW-1:0] touch_age;

  assign touch_age = age[touch_idx];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_age
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        age[g] <= IW'(g);
      end else if (touch_en) begin
        if (touch_idx == IW'(g))       age[g] <= '0;
        else if (age[g] < touch_age)   age[g] <= age[g] + 1'b1;
      end
    end
  end

  // The oldest entry is the unique one holding age ENTRIES-1.
  always_comb begin
    lru_idx = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (age[i] == IW'(ENTRIES - 1)) lru_idx = IW'(i);
  end

endmodule

// File: rtl/victim_cache.sv
// Fully-associative victim cache: parallel lookup, LRU install, dirty writeback, flush.
module victim_cache
  import lc3b_types::*;
#(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 12,
  parameter int LINE_W  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              vic_valid,
  input  logic [ADDR_W-1:0] vic_addr,
  input  logic [LINE_W-1:0] vic_data,
  input  logic              vic_dirty,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [LINE_W-1:0] resp_data,
  output logic              resp_dirty,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [LINE_W-1:0] wb_data,
  input  logic              wb_ready,
  input  logic              flush_req,
  output logic              flush_done
);

  localparam int IW = $clog2(ENTRIES);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } vc_entry_t;

  vc_state_t         state;
  vc_entry_t         ent [ENTRIES];
  logic [ADDR_W-1:0] r_addr;
  logic              r_vic_valid;
  logic [ADDR_W-1:0] r_vic_addr;
  logic [LINE_W-1:0] r_vic_data;
  logic              r_vic_dirty;
  logic [IW-1:0]     flush_idx;

  logic          hit, vic_hit, free;
  logic [IW-1:0] hit_idx, vic_idx, free_idx, tgt, ins_idx, lru_idx;
  logic          need_wb, touch_en;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    vic_hit  = 1'b0;
    vic_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].addr == r_addr) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!ent[i].valid) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent[i].valid && ent[i].addr == r_vic_addr && !(hit && hit_idx == IW'(i))) begin
        vic_hit = 1'b1;
        vic_idx = IW'(i);
      end
    end
    tgt     = free ? free_idx : lru_idx;
    ins_idx = vic_hit ? vic_idx : (hit ? hit_idx : tgt);
    need_wb = r_vic_valid && !hit && !vic_hit && ent[tgt].valid && ent[tgt].dirty;
  end

  assign touch_en  = (state == ST_LOOKUP) && r_vic_valid;
  assign req_ready = (state == ST_IDLE) && !flush_req;

  vc_lru_ages #(.ENTRIES(ENTRIES)) u_lru (
    .clk       (clk),
    .rst_n     (rst_n),
    .touch_en  (touch_en),
    .touch_idx (ins_idx),
    .lru_idx   (lru_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      r_addr      <= '0;
      r_vic_valid <= 1'b0;
      r_vic_addr  <= '0;
      r_vic_data  <= '0;
      r_vic_dirty <= 1'b0;
      flush_idx   <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_data   <= '0;
      resp_dirty  <= 1'b0;
      wb_valid    <= 1'b0;
      wb_addr     <= '0;
      wb_data     <= '0;
      flush_done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (flush_req) begin
            flush_idx <= '0;
            state     <= ST_FLUSH;
          end else if (req_valid) begin
            r_addr      <= req_addr;
            r_vic_valid <= vic_valid;
            r_vic_addr  <= vic_addr;
            r_vic_data  <= vic_data;
            r_vic_dirty <= vic_dirty;
            state       <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          resp_hit   <= hit;
          resp_data  <= hit ? ent[hit_idx].data : '0;
          resp_dirty <= hit && ent[hit_idx].dirty;
          // Exclusive: a hit line leaves unless the victim lands in its slot.
          if (hit && (!r_vic_valid || vic_hit)) ent[hit_idx].valid <= 1'b0;
          if (r_vic_valid)
            ent[ins_idx] <= '{valid: 1'b1, dirty: r_vic_dirty, addr: r_vic_addr, data: r_vic_data};
          if (need_wb) begin
            wb_valid <= 1'b1;
            wb_addr  <= ent[tgt].addr;
            wb_data  <= ent[tgt].data;
            state    <= ST_WB;
          end else begin
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_WB: begin
          if (wb_ready) begin
            wb_valid   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b0;
          state      <= ST_IDLE;
        end
        ST_FLUSH: begin
          ent[flush_idx].valid <= 1'b0;
          ent[flush_idx].dirty <= 1'b0;
          if (ent[flush_idx].valid && ent[flush_idx].dirty) begin
            wb_valid <= 1'b1;
            wb_addr  <= ent[flush_idx].addr;
            wb_data  <= ent[flush_idx].data;
            state    <= ST_FLUSH_WB;
          end else if (flush_idx == IW'(ENTRIES - 1)) begin
            flush_done <= 1'b1;
            state      <= ST_FLUSH_DONE;
          end else begin
            flush_idx <= flush_idx + 1'b1;
          end
        end
        ST_FLUSH_WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (flush_idx == IW'(ENTRIES - 1)) begin
              flush_done <= 1'b1;
              state      <= ST_FLUSH_DONE;
            end else begin
              flush_idx <= flush_idx + 1'b1;
              state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH_DONE: begin
          flush_done <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_victim_cache.sv
// Scoreboarded bench: drivers queue expected responses/writebacks, a negedge monitor checks them.
module tb_victim_cache;

  localparam int AW = 12;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic          req_valid = 1'b0, vic_valid = 1'b0, vic_dirty = 1'b0;
  logic          wb_ready = 1'b0, flush_req = 1'b0;
  logic [AW-1:0] req_addr = '0, vic_addr = '0;
  logic [LW-1:0] vic_data = '0;

  logic          a_req_ready, a_resp_valid, a_resp_hit, a_resp_dirty, a_wb_valid, a_flush_done;
  logic [AW-1:0] a_wb_addr;
  logic [LW-1:0] a_resp_data, a_wb_data;
  logic          b_req_ready, b_resp_valid, b_resp_hit, b_resp_dirty, b_wb_valid, b_flush_done;
  logic [AW-1:0] b_wb_addr;
  logic [LW-1:0] b_resp_data, b_wb_data;

  logic          req_ready, resp_valid, resp_hit, resp_dirty, wb_valid, flush_done;
  logic [AW-1:0] wb_addr;
  logic [LW-1:0] resp_data, wb_data;

  assign req_ready  = sel ? b_req_ready  : a_req_ready;
  assign resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign resp_hit   = sel ? b_resp_hit   : a_resp_hit;
  assign resp_dirty = sel ? b_resp_dirty : a_resp_dirty;
  assign resp_data  = sel ? b_resp_data  : a_resp_data;
  assign wb_valid   = sel ? b_wb_valid   : a_wb_valid;
  assign wb_addr    = sel ? b_wb_addr    : a_wb_addr;
  assign wb_data    = sel ? b_wb_data    : a_wb_data;
  assign flush_done = sel ? b_flush_done : a_flush_done;

  always #5 clk = ~clk;

  victim_cache #(.ENTRIES(8), .ADDR_W(AW), .LINE_W(LW)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && !sel), .req_addr(req_addr), .req_ready(a_req_ready),
    .vic_valid(vic_valid), .vic_addr(vic_addr), .vic_data(vic_data), .vic_dirty(vic_dirty),
    .resp_valid(a_resp_valid), .resp_hit(a_resp_hit), .resp_data(a_resp_data), .resp_dirty(a_resp_dirty),
    .wb_valid(a_wb_valid), .wb_addr(a_wb_addr), .wb_data(a_wb_data), .wb_ready(wb_ready && !sel),
    .flush_req(flush_req && !sel), .flush_done(a_flush_done)
  );

  victim_cache #(.ENTRIES(4), .ADDR_W(AW), .LINE_W(LW)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid && sel), .req_addr(req_addr), .req_ready(b_req_ready),
    .vic_valid(vic_valid), .vic_addr(vic_addr), .vic_data(vic_data), .vic_dirty(vic_dirty),
    .resp_valid(b_resp_valid), .resp_hit(b_resp_hit), .resp_data(b_resp_data), .resp_dirty(b_resp_dirty),
    .wb_valid(b_wb_valid), .wb_addr(b_wb_addr), .wb_data(b_wb_data), .wb_ready(wb_ready && sel),
    .flush_req(flush_req && sel), .flush_done(b_flush_done)
  );

  typedef struct packed { logic hit; logic dirty; logic [LW-1:0] data; } resp_t;
  typedef struct packed { logic [AW-1:0] addr; logic [LW-1:0] data; } wb_t;

  resp_t resp_q[$];
  wb_t   wb_q[$];
  resp_t er;
  wb_t   ew, prev_wb;
  logic  prev_stall = 1'b0;
  int    nvec = 0, nerr = 0, n_done = 0;

  function automatic logic [LW-1:0] dat(input logic [AW-1:0] a);
    return {8{4'hA, a}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response or a writeback handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("wb_stable_valid", LW'(wb_valid), LW'(1));
        chk("wb_stable_addr", LW'(wb_addr), LW'(prev_wb.addr));
        chk("wb_stable_data", wb_data, prev_wb.data);
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL resp_unexpected: got hit=%0b addr-less response, want none", resp_hit);
        end else begin
          er = resp_q.pop_front();
          chk("resp_hit", LW'(resp_hit), LW'(er.hit));
          chk("resp_dirty", LW'(resp_dirty), LW'(er.dirty));
          chk("resp_data", resp_data, er.data);
        end
      end
      if (wb_valid && wb_ready) begin
        if (wb_q.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL wb_unexpected: got addr %0h, want no writeback", wb_addr);
        end else begin
          ew = wb_q.pop_front();
          chk("wb_addr", LW'(wb_addr), LW'(ew.addr));
          chk("wb_data", wb_data, ew.data);
        end
      end
      if (flush_done) n_done++;
      prev_stall = wb_valid && !wb_ready;
      prev_wb    = '{addr: wb_addr, data: wb_data};
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; wb_ready = 1'b0; req_valid = 1'b0; flush_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", LW'(req_ready), LW'(1));
    chk("rst_resp_valid", LW'(resp_valid), LW'(0));
    chk("rst_resp_data", resp_data, LW'(0));
    chk("rst_wb_valid", LW'(wb_valid), LW'(0));
    chk("rst_flush_done", LW'(flush_done), LW'(0));
  endtask

  // One request; latency measured in cycles after the accepting edge.
  task automatic do_req(input logic [AW-1:0] a, input logic vv, input logic [AW-1:0] va,
                        input logic [LW-1:0] vd, input logic vdty,
                        input logic eh, input logic [LW-1:0] ed, input logic edty,
                        input logic ewb, input logic [AW-1:0] wa, input int stall);
    int n, wbc;
    bit got;
    resp_q.push_back('{hit: eh, dirty: edty, data: ed});
    if (ewb) wb_q.push_back('{addr: wa, data: dat(wa)});
    req_addr = a; vic_valid = vv; vic_addr = va; vic_data = vd; vic_dirty = vdty; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; vic_valid = 1'b0;
    n = 1; wbc = 0; got = 0;
    while (n < 200) begin
      if (resp_valid) begin got = 1; break; end
      if (wb_valid) begin wbc++; wb_ready = (wbc > stall); end
      else wb_ready = 1'b0;
      @(posedge clk); #1; n++;
    end
    wb_ready = 1'b0;
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL resp_timeout: got no resp_valid in %0d cycles, want one", n);
    end else begin
      chk("resp_latency", LW'(n), ewb ? LW'(3 + stall) : LW'(2));
    end
    @(posedge clk); #1;
  endtask

  task automatic miss(input logic [AW-1:0] a);
    do_req(a, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic inst(input logic [AW-1:0] a, input logic [AW-1:0] va, input logic vdty);
    do_req(a, 1'b1, va, dat(va), vdty, 1'b0, '0, 1'b0, 1'b0, '0, 0);
  endtask

  task automatic scen3(input int e);
    for (int i = 0; i < e; i++) inst(12'h300 + AW'(i), 12'h100 + AW'(i), 1'b1);
    do_req(12'h300 + AW'(e), 1'b1, 12'h100 + AW'(e), dat(12'h100 + AW'(e)), 1'b1,
           1'b0, '0, 1'b0, 1'b1, 12'h100, 3);
    do_req(12'h100 + AW'(e), 1'b0, '0, '0, 1'b0,
           1'b1, dat(12'h100 + AW'(e)), 1'b1, 1'b0, '0, 0);
  endtask

  task automatic do_flush(input int ndirty, input int e);
    int n, d0;
    d0 = n_done;
    flush_req = 1'b1;
    @(posedge clk); #1;
    flush_req = 1'b0;
    n = 1;
    while (n < 300 && !flush_done) begin
      wb_ready = wb_valid;
      @(posedge clk); #1; n++;
    end
    wb_ready = 1'b0;
    chk("flush_latency", LW'(n), LW'(e + 1 + ndirty));
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("flush_done_pulses", LW'(n_done - d0), LW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want earlier");
    $fatal(1);
  end

  initial begin
    // Empty lookup
    do_reset();
    chk_reset_vals();
    miss(12'h123);

    // Exclusive hit
    do_reset();
    inst(12'h050, 12'h0A0, 1'b1);
    do_req(12'h0A0, 1'b0, '0, '0, 1'b0, 1'b1, dat(12'h0A0), 1'b1, 1'b0, '0, 0);
    miss(12'h0A0);

    // LRU displacement with stalled writeback, then hit with swap
    do_reset();
    scen3(8);
    do_req(12'h103, 1'b1, 12'h200, dat(12'h200), 1'b0, 1'b1, dat(12'h103), 1'b1, 1'b0, '0, 0);
    do_req(12'h200, 1'b0, '0, '0, 1'b0, 1'b1, dat(12'h200), 1'b0, 1'b0, '0, 0);
    miss(12'h103);
    // Victim already resident is overwritten in place, never duplicated
    do_req(12'h999, 1'b1, 12'h104, 128'hBEEF, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 0);
    do_req(12'h104, 1'b0, '0, '0, 1'b0, 1'b1, 128'hBEEF, 1'b0, 1'b0, '0, 0);
    miss(12'h104);

    // Flush with two dirty lines
    do_reset();
    for (int i = 0; i < 8; i++) inst(12'h300 + AW'(i), 12'h100 + AW'(i), (i == 1) || (i == 5));
    wb_q.push_back('{addr: 12'h101, data: dat(12'h101)});
    wb_q.push_back('{addr: 12'h105, data: dat(12'h105)});
    do_flush(2, 8);
    for (int i = 0; i < 8; i++) miss(12'h100 + AW'(i));

    // Reset in the middle of a displacing writeback
    do_reset();
    for (int i = 0; i < 8; i++) inst(12'h300 + AW'(i), 12'h100 + AW'(i), 1'b1);
    req_addr = 12'h308; vic_valid = 1'b1; vic_addr = 12'h108; vic_data = dat(12'h108);
    vic_dirty = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; vic_valid = 1'b0;
    @(posedge clk); #1;
    chk("wb_before_reset", LW'(wb_valid), LW'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("wb_after_reset", LW'(wb_valid), LW'(0));
    chk("resp_after_reset", LW'(resp_valid), LW'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) miss(12'h100 + AW'(i));

    // Small configuration
    sel = 1'b1;
    do_reset();
    chk_reset_vals();
    scen3(4);

    repeat (3) @(posedge clk);
    #1;
    chk("resp_q_drained", LW'(resp_q.size()), LW'(0));
    chk("wb_q_drained", LW'(wb_q.size()), LW'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
